// File: rtl/multi_strobe_pkg.sv
// ----------------------------------------------------------------------------
// Package: multi_strobe_pkg
// Purpose : Shared types and helpers for the multi-channel strobe divider.
//           Holds the default field widths, the per-channel configuration
//           record (period + pulse width) and the clamping function that
//           turns a raw programmed configuration into the values the
//           counters actually run with.
// Contents:
//   DEF_CNT_W  width of the period counter / period field
//   DEF_PW_W   width of the pulse-width field
//   ch_cfg_t   packed {div, pw} configuration record
//   eff_cfg()  raw ch_cfg_t -> effective (clamped) ch_cfg_t
// ----------------------------------------------------------------------------
package multi_strobe_pkg;

    localparam int DEF_CNT_W = 30;
    localparam int DEF_PW_W  = 4;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] div;
        logic [DEF_PW_W-1:0]  pw;
    } ch_cfg_t;

    // Clamp a programmed configuration into something the counter can run:
    // a zero period behaves as a period of one, and the pulse width is held
    // between 1 and period-1 so every period has at least one low cycle
    // (except the period-of-one case, where the strobe simply stays high).
    function automatic ch_cfg_t eff_cfg(input ch_cfg_t raw);
        ch_cfg_t              res;
        logic [DEF_CNT_W-1:0] d_eff;
        logic [DEF_CNT_W-1:0] d_m1;
        logic [DEF_CNT_W-1:0] p_ext;
        logic [DEF_CNT_W-1:0] p_min;
        d_eff = (raw.div == '0) ? DEF_CNT_W'(1) : raw.div;
        d_m1  = d_eff - DEF_CNT_W'(1);
        p_ext = DEF_CNT_W'(raw.pw);
        p_min = (p_ext < d_m1) ? p_ext : d_m1;
        if (p_min == '0) begin
            p_min = DEF_CNT_W'(1);
        end
        res.div = d_eff;
        // p_min never exceeds the programmed pw (or is 1), so it fits PW_W.
        res.pw  = DEF_PW_W'(p_min);
        return res;
    endfunction

endpackage

// File: rtl/strobe_channel.sv
// ----------------------------------------------------------------------------
// Module : strobe_channel
// Purpose: One strobe generator. Runs a wrap-around period counter from the
//          active configuration and produces a registered strobe that is
//          high for the last P_eff cycles of every D_eff-cycle period.
//          New configurations wait in a shadow register and are copied to
//          the active one only at a period boundary (or immediately while
//          the channel is idle / being restarted), so a running strobe
//          never sees a half-old, half-new period.
// Ports  :
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   en            channel enable (level)
//   sync_restart  one-cycle pulse: zero the counter, apply pending config
//   wr_en         accepted configuration write for this channel
//   wr_cfg        configuration carried by that write
//   strobe        registered strobe output
//   pending       a shadow configuration is waiting to be applied
// ----------------------------------------------------------------------------
module strobe_channel
    import multi_strobe_pkg::*;
#(
    parameter int DEFAULT_DIV = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    en,
    input  logic    sync_restart,
    input  logic    wr_en,
    input  ch_cfg_t wr_cfg,
    output logic    strobe,
    output logic    pending
);

    localparam ch_cfg_t RESET_CFG = '{div: DEF_CNT_W'(DEFAULT_DIV), pw: DEF_PW_W'(1)};

    logic [DEF_CNT_W-1:0] cnt_q, cnt_d;
    logic                 strobe_q, strobe_d;
    logic                 pending_q, pending_d;
    ch_cfg_t              active_q, active_d;
    ch_cfg_t              shadow_q, shadow_d;

    ch_cfg_t              eff;
    logic [DEF_CNT_W-1:0] threshold;
    logic                 at_terminal;
    logic [DEF_CNT_W-1:0] cnt_inc;
    logic                 apply_now;

    // Derive the running values from the active configuration: the count at
    // which the strobe turns on, whether this cycle is the last of the
    // period, and what the counter would advance to if left running.
    always_comb begin
        eff         = eff_cfg(active_q);
        threshold   = eff.div - DEF_CNT_W'(eff.pw);
        at_terminal = (cnt_q == (eff.div - DEF_CNT_W'(1)));
        cnt_inc     = at_terminal ? '0 : (cnt_q + DEF_CNT_W'(1));
    end

    // Next-state logic. A restart or a disabled channel parks the counter at
    // zero with the strobe low; since the counter is not mid-period, any
    // waiting configuration may be taken at once. A running channel only
    // takes a waiting configuration on the cycle it wraps, so the period in
    // flight always finishes with the old values. An accepted write can only
    // arrive while nothing is pending, so it never collides with an apply.
    always_comb begin
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        apply_now = 1'b0;

        if (sync_restart || !en) begin
            cnt_d     = '0;
            apply_now = pending_q;
        end else begin
            cnt_d     = cnt_inc;
            strobe_d  = (cnt_inc >= threshold);
            apply_now = pending_q && at_terminal;
        end

        if (apply_now) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (wr_en) begin
            shadow_d  = wr_cfg;
            pending_d = 1'b1;
        end
    end

    // State registers. Reset returns the channel to the default period with
    // the shadow mirroring the active configuration and nothing pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            strobe_q  <= 1'b0;
            pending_q <= 1'b0;
            active_q  <= RESET_CFG;
            shadow_q  <= RESET_CFG;
        end else begin
            cnt_q     <= cnt_d;
            strobe_q  <= strobe_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
        end
    end

    assign strobe  = strobe_q;
    assign pending = pending_q;

endmodule

// File: rtl/multi_strobe_divider.sv
// ----------------------------------------------------------------------------
// Module : multi_strobe_divider
// Purpose: NUM_CH independent strobe channels sharing one clock, each with a
//          runtime-programmable period and pulse width, a per-channel enable
//          and a global phase-align restart. Configuration goes through a
//          single write port with a per-channel ready handshake.
// Ports  :
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   cfg_we        configuration write strobe (taken only when cfg_ready=1)
//   cfg_ch        target channel; values >= NUM_CH are ignored
//   cfg_div       new period in clk cycles
//   cfg_pw        new pulse width in clk cycles
//   cfg_ready     combinational: addressed channel has no write pending
//   ch_en         per-channel enable, level
//   sync_restart  one-cycle pulse, phase-aligns every channel
//   strobe        registered strobe outputs, one per channel
// The period/pulse fields are carried in the package record, so CNT_W and
// PW_W are expected to stay at the package widths.
// ----------------------------------------------------------------------------
module multi_strobe_divider
    import multi_strobe_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = DEF_CNT_W,
    parameter  int PW_W        = DEF_PW_W,
    parameter  int DEFAULT_DIV = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [PW_W-1:0]   cfg_pw,
    output logic              cfg_ready,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] strobe
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_sel;
    logic              ready_sel;
    ch_cfg_t           wr_cfg;

    assign wr_cfg = '{div: cfg_div, pw: cfg_pw};

    // Address decode. Ready reflects the addressed channel's pending flag;
    // an address with no channel behind it reports ready and simply selects
    // nobody, so such a write falls on the floor.
    always_comb begin
        ready_sel = 1'b1;
        wr_sel    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ready_sel = !pending[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_we && ready_sel && (cfg_ch == CH_W'(i));
        end
    end

    assign cfg_ready = ready_sel;

    // One generator per channel; the restart pulse fans out to all of them.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        strobe_channel #(
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .en           (ch_en[g]),
            .sync_restart (sync_restart),
            .wr_en        (wr_sel[g]),
            .wr_cfg       (wr_cfg),
            .strobe       (strobe[g]),
            .pending      (pending[g])
        );
    end

endmodule

// File: tb/tb_multi_strobe_divider.sv
// ----------------------------------------------------------------------------
// Testbench for multi_strobe_divider. The main instance runs four channels
// against a cycle-level reference model; each stimulus cycle pushes the
// model's expected strobe vector to a queue which is popped and compared
// once the DUT has clocked. Directed checks with fixed expected values cover
// the timing landmarks (counts of high cycles, first-high offsets after a
// restart, handshake state). A second three-channel instance exercises a
// channel address with no channel behind it.
// ----------------------------------------------------------------------------
module tb_multi_strobe_divider;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [29:0] cfg_div;
    logic [3:0]  cfg_pw;
    logic        cfg_ready;
    logic [3:0]  ch_en;
    logic        sync_restart;
    logic [3:0]  strobe;

    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [29:0] cfg_div3;
    logic [3:0]  cfg_pw3;
    logic        cfg_ready3;
    logic [2:0]  ch_en3;
    logic        sync3;
    logic [2:0]  strobe3;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, one entry per channel.
    int m_cnt  [4];
    int m_div  [4];
    int m_pw   [4];
    int m_sdiv [4];
    int m_spw  [4];
    bit m_pend [4];

    logic [3:0] exp_q[$];
    logic [3:0] cur_en;
    logic [1:0] cur_ch;

    multi_strobe_divider #(
        .NUM_CH (4), .CNT_W (30), .PW_W (4), .DEFAULT_DIV (1)
    ) u_dut (
        .clk (clk), .reset (reset), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_div (cfg_div), .cfg_pw (cfg_pw), .cfg_ready (cfg_ready),
        .ch_en (ch_en), .sync_restart (sync_restart), .strobe (strobe)
    );

    multi_strobe_divider #(
        .NUM_CH (3), .CNT_W (30), .PW_W (4), .DEFAULT_DIV (1)
    ) u_dut3 (
        .clk (clk), .reset (reset), .cfg_we (cfg_we3), .cfg_ch (cfg_ch3),
        .cfg_div (cfg_div3), .cfg_pw (cfg_pw3), .cfg_ready (cfg_ready3),
        .ch_en (ch_en3), .sync_restart (sync3), .strobe (strobe3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: sequence did not complete (observed timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int deff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int peff(input int d, input int p);
        int de;
        int pe;
        de = deff(d);
        pe = p;
        if (pe > de - 1) pe = de - 1;
        if (pe < 1) pe = 1;
        return pe;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = 1;
            m_pw[i]   = 1;
            m_sdiv[i] = 1;
            m_spw[i]  = 1;
            m_pend[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the currently driven inputs and
    // return the strobe vector expected right after the edge.
    task automatic modelStep(output logic [3:0] nxt);
        int sel;
        bit acc;
        sel = int'(cfg_ch);
        acc = cfg_we && !m_pend[sel];
        for (int i = 0; i < 4; i++) begin
            int de;
            int pe;
            bit take;
            de     = deff(m_div[i]);
            pe     = peff(m_div[i], m_pw[i]);
            nxt[i] = 1'b0;
            take   = 1'b0;
            if (sync_restart || !ch_en[i]) begin
                m_cnt[i] = 0;
                take     = m_pend[i];
            end else begin
                if (m_cnt[i] == de - 1) begin
                    m_cnt[i] = 0;
                    take     = m_pend[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                nxt[i] = (m_cnt[i] >= de - pe);
            end
            if (take) begin
                m_div[i]  = m_sdiv[i];
                m_pw[i]   = m_spw[i];
                m_pend[i] = 1'b0;
            end
            if (acc && sel == i) begin
                m_sdiv[i] = int'(cfg_div);
                m_spw[i]  = int'(cfg_pw);
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check the combinational ready against the
    // model, queue the expected strobe, clock, then pop and compare.
    task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [29:0] div,
                                 input logic [3:0] pw, input logic [3:0] en, input logic sync);
        logic [3:0] exp_s;
        logic       exp_ready;
        cfg_we       = we;
        cfg_ch       = ch;
        cfg_div      = div;
        cfg_pw       = pw;
        ch_en        = en;
        sync_restart = sync;
        #1;
        exp_ready = !m_pend[int'(ch)];
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        modelStep(exp_s);
        exp_q.push_back(exp_s);
        @(posedge clk);
        #1;
        cfg_we       = 1'b0;
        sync_restart = 1'b0;
        if (exp_q.size() == 0) begin
            checkOutput("strobe_queue_empty", 32'(1), 32'(0));
        end else begin
            checkOutput("strobe", 32'(strobe), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, cur_ch, 30'd0, 4'd0, cur_en, 1'b0);
        end
    endtask

    task automatic cfgWrite(input logic [1:0] ch, input logic [29:0] div, input logic [3:0] pw);
        cur_ch = ch;
        applyStimulus(1'b1, ch, div, pw, cur_en, 1'b0);
    endtask

    task automatic countHighs(input int ch, input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            idle(1);
            c += int'(strobe[ch]);
        end
    endtask

    initial begin
        int c;
        int first0;
        int first1;

        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_ch       = 2'd0;
        cfg_div      = '0;
        cfg_pw       = '0;
        ch_en        = 4'b0000;
        sync_restart = 1'b0;
        cfg_we3      = 1'b0;
        cfg_ch3      = 2'd0;
        cfg_div3     = '0;
        cfg_pw3      = '0;
        ch_en3       = 3'b111;
        sync3        = 1'b0;
        cur_en       = 4'b0000;
        cur_ch       = 2'd0;
        modelReset();

        // 1: reset state, default period of one on channel 0
        #12;
        reset = 1'b0;
        #1;
        checkOutput("reset_strobe", 32'(strobe), 32'(0));
        checkOutput("reset_ready", 32'(cfg_ready), 32'(1));
        cur_en = 4'b0001;
        idle(8);
        checkOutput("default_div_ch0_high", 32'(strobe), 32'(4'b0001));

        // 2: period/pulse programming on channel 0
        cfgWrite(2'd0, 30'd4, 4'd1);
        idle(3);
        countHighs(0, 20, c);
        checkOutput("d4p1_highs_in_20", 32'(c), 32'(5));
        cfgWrite(2'd0, 30'd5, 4'd2);
        idle(6);
        countHighs(0, 20, c);
        checkOutput("d5p2_highs_in_20", 32'(c), 32'(8));

        // 3: handshake on channel 1, second write dropped while pending
        cur_en = 4'b0011;
        cfgWrite(2'd1, 30'd4, 4'd1);
        idle(6);
        cfgWrite(2'd1, 30'd8, 4'd1);
        checkOutput("ready_busy_after_write", 32'(cfg_ready), 32'(0));
        cfgWrite(2'd1, 30'd2, 4'd1);
        idle(4);
        checkOutput("ready_after_apply", 32'(cfg_ready), 32'(1));
        idle(6);
        countHighs(1, 16, c);
        checkOutput("d8_highs_in_16", 32'(c), 32'(2));

        // 4: phase-align restart
        cfgWrite(2'd0, 30'd3, 4'd1);
        idle(6);
        cfgWrite(2'd1, 30'd7, 4'd1);
        idle(9);
        applyStimulus(1'b0, cur_ch, 30'd0, 4'd0, cur_en, 1'b1);
        checkOutput("restart_strobe_low", 32'(strobe[1:0]), 32'(0));
        first0 = -1;
        first1 = -1;
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            if (first0 < 0 && strobe[0]) first0 = k;
            if (first1 < 0 && strobe[1]) first1 = k;
        end
        checkOutput("restart_ch0_first_high", 32'(first0), 32'(2));
        checkOutput("restart_ch1_first_high", 32'(first1), 32'(6));
        cur_ch = 2'd0;
        applyStimulus(1'b1, 2'd0, 30'd6, 4'd1, cur_en, 1'b1);
        checkOutput("restart_write_stays_pending", 32'(cfg_ready), 32'(0));
        idle(8);

        // 5: edge cases
        cur_en = 4'b1111;
        cfgWrite(2'd2, 30'd0, 4'd3);
        cfgWrite(2'd3, 30'd4, 4'd15);
        idle(4);
        countHighs(2, 8, c);
        checkOutput("d0_as_d1_highs_in_8", 32'(c), 32'(8));
        countHighs(3, 8, c);
        checkOutput("p15_d4_highs_in_8", 32'(c), 32'(6));

        checkOutput("dut3_default_high", 32'(strobe3), 32'(3'b111));
        cfg_we3  = 1'b1;
        cfg_ch3  = 2'd3;
        cfg_div3 = 30'd4;
        cfg_pw3  = 4'd1;
        idle(1);
        cfg_we3 = 1'b0;
        idle(5);
        checkOutput("dut3_out_of_range_ignored", 32'(strobe3), 32'(3'b111));
        for (int k = 0; k < 3; k++) begin
            cfg_ch3 = 2'(k);
            #1;
            checkOutput("dut3_ready_untouched", 32'(cfg_ready3), 32'(1));
        end

        cur_en = 4'b1110;
        idle(1);
        checkOutput("ch_en_drop_strobe0", 32'(strobe[0]), 32'(0));
        idle(3);

        // 6: asynchronous reset mid-pulse with a write pending on channel 1
        cfgWrite(2'd1, 30'd3, 4'd1);
        cfg_ch = 2'd1;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_strobe", 32'(strobe), 32'(0));
        checkOutput("async_reset_ready", 32'(cfg_ready), 32'(1));
        checkOutput("async_reset_strobe3", 32'(strobe3), 32'(0));
        #2;
        reset = 1'b0;
        modelReset();
        exp_q.delete();
        cur_en = 4'b0010;
        idle(4);
        checkOutput("post_reset_default_div", 32'(strobe), 32'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
